// File: rtl/khazad_inv_key_sched.sv
// khazad_inv_key_sched: buffers R+1 KHAZAD encryption round keys and replays them reversed, theta on inner keys.
// Optional macro KHAZAD_INV_KEY_OUTREG_EN registers the dk outputs behind a one-cycle PRIME state.
module theta (
    input  logic [63:0] a,
    output logic [63:0] b
);
    // GF(2^8) with x^8+x^4+x^3+x^2+1; byte 0 is the most significant byte
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction
    function automatic logic [7:0] mul(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction
    // first row of the involutional MDS matrix, H[i][j] = h[i^j]
    localparam logic [31:0] H = 32'h1345_68B7;
    always_comb begin
        b = '0;
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < 8; i++)
                b[63-8*j -: 8] = b[63-8*j -: 8] ^ mul(a[63-8*i -: 8], H[31-4*(i^j) -: 4]);
    end
endmodule

module khazad_inv_key_sched #(
    parameter int ROUNDS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ek_valid,
    output logic        ek_ready,
    input  logic [63:0] ek_data,
    output logic        dk_valid,
    input  logic        dk_ready,
    output logic [63:0] dk_data,
    output logic [3:0]  dk_index,
    output logic        dk_last
);
    localparam logic [3:0] R = 4'(ROUNDS);
`ifdef KHAZAD_INV_KEY_OUTREG_EN
    typedef enum logic [1:0] {LOAD, PRIME, EMIT} state_t;
    localparam state_t AFTER_LOAD = PRIME;
`else
    typedef enum logic [1:0] {LOAD, EMIT} state_t;
    localparam state_t AFTER_LOAD = EMIT;
`endif
    state_t      state, state_n;
    logic [63:0] key [0:ROUNDS];
    logic [3:0]  wp, rp, sel;
    logic [63:0] src, thet, entry;
    logic        ek_fire, dk_fire;
    assign ek_fire  = ek_valid & ek_ready;
    assign dk_fire  = dk_valid & dk_ready;
    assign dk_valid = state == EMIT;
    // entry r reads key[R-r]; the outer two bypass theta
    assign src   = key[R - sel];
    assign entry = (sel == 4'd0 || sel == R) ? src : thet;
    theta u_theta (
        .a(src),
        .b(thet)
    );
    always_comb begin
        state_n = state;
        if (ek_fire && wp == R) state_n = AFTER_LOAD;
`ifdef KHAZAD_INV_KEY_OUTREG_EN
        if (state == PRIME) state_n = EMIT;
`endif
        if (dk_fire && rp == R) state_n = LOAD;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= LOAD;
            wp       <= '0;
            rp       <= '0;
            ek_ready <= 1'b0;
        end else begin
            state    <= state_n;
            ek_ready <= state_n == LOAD;
            if (ek_fire) wp <= (wp == R) ? 4'd0 : wp + 4'd1;
            if (dk_fire) rp <= (rp == R) ? 4'd0 : rp + 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (ek_fire) key[wp] <= ek_data;
    end
`ifdef KHAZAD_INV_KEY_OUTREG_EN
    // prefetch the entry the consumer will see after the current handshake
    assign sel = (state == PRIME || rp == R) ? 4'd0 : rp + 4'd1;
    always_ff @(posedge clk) begin
        if (!reset_n || (dk_fire && rp == R)) begin
            dk_data  <= '0;
            dk_index <= '0;
            dk_last  <= 1'b0;
        end else if (state == PRIME || dk_fire) begin
            dk_data  <= entry;
            dk_index <= sel;
            dk_last  <= sel == R;
        end
    end
`else
    assign sel      = rp;
    assign dk_data  = dk_valid ? entry : 64'd0;
    assign dk_index = dk_valid ? rp : 4'd0;
    assign dk_last  = dk_valid && rp == R;
`endif
endmodule

// File: tb/tb_khazad_inv_key_sched.sv
// tb_khazad_inv_key_sched: directed + random checks of key reversal, theta, backpressure, reset and turnaround.
module tb_khazad_inv_key_sched;
    localparam int R = 8;
`ifdef KHAZAD_INV_KEY_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic        clk = 0, reset_n = 0, ek_valid = 0, dk_ready = 0;
    logic [63:0] ek_data = '0;
    logic        ek_ready, dk_valid, dk_last;
    logic [63:0] dk_data;
    logic [3:0]  dk_index;
    int          n_cmp = 0, n_bad = 0;
    logic [63:0] keys [0:R];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    khazad_inv_key_sched #(.ROUNDS(R)) dut (
        .clk(clk), .reset_n(reset_n), .ek_valid(ek_valid), .ek_ready(ek_ready), .ek_data(ek_data),
        .dk_valid(dk_valid), .dk_ready(dk_ready), .dk_data(dk_data), .dk_index(dk_index), .dk_last(dk_last)
    );

    // carry-less product reduced modulo 0x11D
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11D << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [63:0] theta_ref(input logic [63:0] x);
        logic [7:0] h [8];
        logic [7:0] a [8];
        logic [7:0] acc;
        logic [63:0] y;
        h[0] = 8'h01; h[1] = 8'h03; h[2] = 8'h04; h[3] = 8'h05;
        h[4] = 8'h06; h[5] = 8'h08; h[6] = 8'h0B; h[7] = 8'h07;
        for (int i = 0; i < 8; i++) a[i] = x[63-8*i -: 8];
        y = '0;
        for (int j = 0; j < 8; j++) begin
            acc = '0;
            for (int i = 0; i < 8; i++) acc = acc ^ gmul(a[i], h[i ^ j]);
            y[63-8*j -: 8] = acc;
        end
        return y;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int r = 0; r <= R; r++)
            exp_q.push_back(r == 0 ? keys[R] : r == R ? keys[0] : theta_ref(keys[R - r]));
    endtask

    task automatic rand_keys();
        for (int i = 0; i <= R; i++) keys[i] = {$urandom, $urandom};
    endtask

    // called at a negedge; returns at the negedge after the last accept
    task automatic load_set();
        int w = 0;
        while (!ek_ready && w < 20) begin @(negedge clk); w++; end
        check("ek_ready_before_load", 64'(ek_ready), 64'd1);
        for (int i = 0; i <= R; i++) begin
            check("ek_ready_during_load", 64'(ek_ready), 64'd1);
            ek_valid = 1;
            ek_data  = keys[i];
            @(negedge clk);
        end
        ek_valid = 0;
        check("ek_ready_drop", 64'(ek_ready), 64'd0);
        build_exp();
    endtask

    // mode 0: dk_ready held high; mode 1: 5-cycle stall at r=3, random elsewhere
    task automatic drain(input int mode, input bit garbage, input int rst_at);
        int lat = 1, r = 0, stall = 0, cyc = 0;
        logic [63:0] hd;
        logic [3:0]  hi;
        bit held = 0;
        while (!dk_valid && lat < 10) begin @(negedge clk); lat++; end
        check("first_key_latency", 64'(lat), 64'(LAT));
        while (r <= R && cyc < 200) begin
            cyc++;
            if (held) begin
                check("stall_data", dk_data, hd);
                check("stall_index", 64'(dk_index), 64'(hi));
            end
            check("dk_valid", 64'(dk_valid), 64'd1);
            check("dk_index", 64'(dk_index), 64'(r));
            check("dk_data", dk_data, exp_q[r]);
            check("dk_last", 64'(dk_last), 64'(r == R));
            if (garbage) begin
                ek_valid = 1;
                ek_data  = {$urandom, $urandom};
                check("ek_ready_in_emit", 64'(ek_ready), 64'd0);
            end
            if (r == rst_at) begin
                reset_n  = 0;
                dk_ready = 1;
                @(negedge clk);
                check("rst_dk_valid", 64'(dk_valid), 64'd0);
                check("rst_ek_ready", 64'(ek_ready), 64'd0);
                check("rst_dk_index", 64'(dk_index), 64'd0);
                check("rst_dk_last", 64'(dk_last), 64'd0);
                check("rst_dk_data", dk_data, 64'd0);
                reset_n  = 1;
                dk_ready = 0;
                ek_valid = 0;
                @(negedge clk);
                check("ek_ready_after_reset", 64'(ek_ready), 64'd1);
                return;
            end
            if (mode == 0) dk_ready = 1;
            else if (r == 3 && stall < 5) begin dk_ready = 0; stall++; end
            else if (r == 3) dk_ready = 1;
            else dk_ready = 1'($urandom);
            held = !dk_ready;
            hd   = dk_data;
            hi   = dk_index;
            @(negedge clk);
            if (dk_ready) r++;
        end
        dk_ready = 0;
        ek_valid = 0;
        check("all_keys_emitted", 64'(r), 64'(R + 1));
        if (mode == 0) check("emit_throughput_cycles", 64'(cyc), 64'(R + 1));
        if (mode == 1) check("stall_cycles_at_r3", 64'(stall), 64'd5);
        check("dk_valid_after_emit", 64'(dk_valid), 64'd0);
        check("ek_ready_turnaround", 64'(ek_ready), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ek_ready", 64'(ek_ready), 64'd0);
        check("reset_dk_valid", 64'(dk_valid), 64'd0);
        check("reset_dk_index", 64'(dk_index), 64'd0);
        check("reset_dk_last", 64'(dk_last), 64'd0);
        check("reset_dk_data", dk_data, 64'd0);
        reset_n = 1;
        @(negedge clk);
        check("ek_ready_first_edge", 64'(ek_ready), 64'd1);
        for (int i = 0; i <= R; i++) keys[i] = '0;
        keys[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        keys[R] = 64'h5555_5555_5555_5555;
        load_set();
        drain(0, 0, -1);
        rand_keys(); load_set(); drain(0, 0, -1);
        rand_keys(); load_set(); drain(1, 0, -1);
        rand_keys(); load_set(); drain(0, 1, -1);
        rand_keys(); load_set(); drain(1, 0, -1);
        rand_keys(); load_set(); drain(0, 0, 4);
        rand_keys(); load_set(); drain(0, 0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
